risc_prog_loader: RTL and testbench
===================================

# risc_prog_loader

Program loader and run controller placed directly upstream of the 16-bit `Risc` core. It accepts instruction words over a valid/ready stream and writes them sequentially into the core's instruction memory through its external write port (`ext_we`/`ext_data`, plus an explicit address). It holds the core's `PC_rst` low throughout loading and for a fixed settle window, then releases it. It watches the core's `done` and counts execution cycles.

## Interface
Parameters:
- `DEPTH`, 256: instruction memory words; address width is clog2(DEPTH).
- `RST_HOLD`, 9: cycles `cpu_rst` stays low after the last write.
- `HLT_WORD`, 16'hE001: terminating instruction, and the end-of-load marker.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a load; honoured in IDLE and HALTED only.
- `in_data`  in  16  instruction word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a word this cycle.
- `ext_we`  out  1  memory write strobe to the core.
- `ext_data`  out  16  word being written.
- `ext_addr`  out  clog2(DEPTH)  write address.
- `cpu_rst`  out  1  drives the core's `PC_rst` (active-low).
- `cpu_done`  in  1  core's `done`.
- `busy`  out  1  state is not IDLE and not HALTED.
- `err`  out  1  overflow: DEPTH words accepted without `HLT_WORD`.
- `run_cycles`  out  16  cycles spent in RUN, saturating at 16'hFFFF.

## Operation
- Reset values: state IDLE; `cpu_rst`=0, `ext_we`=0, `ext_data`=0, `ext_addr`=0, `in_ready`=0, `busy`=0, `err`=0, `run_cycles`=0; internal write pointer 0.
- IDLE: on `start`, go to LOAD, clear pointer, `err` and `run_cycles`.
- LOAD: `in_ready`=1, decoded from state. A handshake (`in_valid`&`in_ready`) registers `ext_we`=1, `ext_data`=`in_data`, `ext_addr`=pointer, then increments the pointer. A cycle with no handshake registers `ext_we`=0.
  - If the accepted word equals `HLT_WORD`, go to HOLD on the same edge.
  - If the accepted word fills address DEPTH-1 and is not `HLT_WORD`, it is still written, `err` is set, and the state goes to IDLE. `cpu_rst` stays 0.
- HOLD: `in_ready`=0 and `cpu_rst`=0. The hold counter loads RST_HOLD-1 on entry and decrements each cycle. At 0, go to RUN and register `cpu_rst`=1.
- RUN: `cpu_rst`=1 and `run_cycles` increments each cycle (saturating). When `cpu_done`=1, go to HALTED; `run_cycles` is frozen and excludes the done cycle.
- HALTED: `cpu_rst` stays 1 and outputs hold. On `start`, go to LOAD and drop `cpu_rst` to 0 on the same edge.
- `start` is ignored in LOAD, HOLD and RUN. `cpu_done` is ignored outside RUN.
- Pointer arithmetic is unsigned with width clog2(DEPTH). It never wraps, because overflow exits LOAD first.

## Timing
- Write latency: a handshake at edge k gives `ext_we`/`ext_data`/`ext_addr` valid for exactly the cycle after edge k. Back-to-back handshakes give one write per cycle with no bubbles.
- Last-word handshake at edge k:
  - `ext_we` is high for cycle k..k+1.
  - `in_ready` is low from edge k.
  - `cpu_rst` rises at edge k+RST_HOLD.
- The `cpu_done` sample at edge m gives the HALTED state and `busy`=0 from edge m.
- Asynchronous reset in any state, including mid-load or mid-run, forces the reset values immediately. `cpu_rst` goes 0 without waiting for a clock.
- All outputs are registered except `in_ready` and `busy`, which are state decodes.

## Structure
- Shared package `risc_pkg` holds:
  - `DATA_W`=16 and `HLT_WORD`;
  - the opcode constants used by benches;
  - the loader state enum IDLE/LOAD/HOLD/RUN/HALTED.
- A single module; no sub-module is warranted. The hold counter and pointer are inline registers.

## Test plan
- Load 0x18A0, 0x19C0, 0x0204, 0x2AE0, 0xE001 back-to-back with DEPTH=256 -> writes to addresses 0..4 on consecutive cycles, `cpu_rst` rises 9 cycles after the HLT handshake, and `busy`=1.
- Same program with `in_valid` low every other cycle -> identical addresses and data, no write on idle cycles, and `ext_we` pulses one cycle each.
- With DEPTH=8, send 8 words without 0xE001 -> address 7 is written, `err`=1, state IDLE, `cpu_rst` never rises, and `in_ready`=0.
- After load, assert `cpu_done` 40 cycles after `cpu_rst` rises -> `run_cycles`=40, `busy`=0, `cpu_rst` stays 1, and the next `start` drops `cpu_rst` and clears `run_cycles`.
- Assert `rst` low during word 3 of a load and during RUN -> all outputs return to reset values asynchronously, and a fresh `start` reloads from address 0.
- Pulse `start` during LOAD and during HOLD -> no effect on pointer, hold count or outputs.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the Risc core and its program loader.
package risc_pkg;

   localparam int          DATA_W   = 16;
   localparam logic [15:0] HLT_WORD = 16'hE001;

   // Opcode field is the top nibble of each instruction word.
   localparam logic [3:0] OP_ALU   = 4'h0;
   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_HALT  = 4'hE;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_HOLD,
      S_RUN,
      S_HALTED
   } loader_state_e;

endpackage

// File: rtl/risc_prog_loader.sv
// Streams a program into the Risc instruction memory, holds the core in reset
// for a settle window, then releases it and counts cycles until it reports done.
module risc_prog_loader #(
   parameter int          DEPTH    = 256,
   parameter int          RST_HOLD = 9,
   parameter logic [15:0] HLT_WORD = risc_pkg::HLT_WORD
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [15:0]              in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic                     ext_we,
   output logic [15:0]              ext_data,
   output logic [$clog2(DEPTH)-1:0] ext_addr,
   output logic                     cpu_rst,
   input  logic                     cpu_done,
   output logic                     busy,
   output logic                     err,
   output logic [15:0]              run_cycles
);
   import risc_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

   loader_state_e     state_q, state_d;
   logic [AW-1:0]     ptr_q, ptr_d;
   logic [HW-1:0]     hold_q, hold_d;
   logic              ext_we_q, ext_we_d;
   logic [DATA_W-1:0] ext_data_q, ext_data_d;
   logic [AW-1:0]     ext_addr_q, ext_addr_d;
   logic              cpu_rst_q, cpu_rst_d;
   logic              err_q, err_d;
   logic [15:0]       run_q, run_d;
   logic              handshake;

   assign in_ready  = (state_q == S_LOAD);
   assign busy      = (state_q != S_IDLE) && (state_q != S_HALTED);
   assign handshake = in_valid && in_ready;

   // NOTE: every signal gets its hold value first so no branch can leave one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      hold_d     = hold_q;
      ext_we_d   = 1'b0;
      ext_data_d = ext_data_q;
      ext_addr_d = ext_addr_q;
      cpu_rst_d  = cpu_rst_q;
      err_d      = err_q;
      run_d      = run_q;

      case (state_q)
         S_IDLE, S_HALTED: begin
            if (start) begin
               state_d   = S_LOAD;
               ptr_d     = '0;
               err_d     = 1'b0;
               run_d     = '0;
               cpu_rst_d = 1'b0;
            end
         end
         S_LOAD: begin
            if (handshake) begin
               ext_we_d   = 1'b1;
               ext_data_d = in_data;
               ext_addr_d = ptr_q;
               ptr_d      = ptr_q + AW'(1);
               if (in_data == HLT_WORD) begin
                  state_d = S_HOLD;
                  hold_d  = HW'(RST_HOLD - 1);
               end else if (ptr_q == AW'(DEPTH - 1)) begin
                  // Memory full without a halt: the program cannot terminate.
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_HOLD: begin
            if (hold_q == '0) begin
               state_d   = S_RUN;
               cpu_rst_d = 1'b1;
            end else begin
               hold_d = hold_q - HW'(1);
            end
         end
         S_RUN: begin
            if (cpu_done) begin
               state_d = S_HALTED;
            end else if (run_q != 16'hFFFF) begin
               run_d = run_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         hold_q     <= '0;
         ext_we_q   <= 1'b0;
         ext_data_q <= '0;
         ext_addr_q <= '0;
         cpu_rst_q  <= 1'b0;
         err_q      <= 1'b0;
         run_q      <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         hold_q     <= hold_d;
         ext_we_q   <= ext_we_d;
         ext_data_q <= ext_data_d;
         ext_addr_q <= ext_addr_d;
         cpu_rst_q  <= cpu_rst_d;
         err_q      <= err_d;
         run_q      <= run_d;
      end
   end

   assign ext_we     = ext_we_q;
   assign ext_data   = ext_data_q;
   assign ext_addr   = ext_addr_q;
   assign cpu_rst    = cpu_rst_q;
   assign err        = err_q;
   assign run_cycles = run_q;

endmodule

// File: tb/tb_risc_prog_loader.sv
// Directed bench for risc_prog_loader: a DEPTH=256 instance for the main flows
// and a DEPTH=8 instance for memory overflow.
module tb_risc_prog_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        start8 = 1'b0;
   logic [15:0] in_data = 16'h0;
   logic        in_valid = 1'b0;
   logic        cpu_done = 1'b0;

   logic        in_ready, ext_we, cpu_rst, busy, err;
   logic [15:0] ext_data, run_cycles;
   logic [7:0]  ext_addr;

   logic        in_ready_8, ext_we_8, cpu_rst_8, busy_8, err_8;
   logic [15:0] ext_data_8, run_cycles_8;
   logic [2:0]  ext_addr_8;

   int checks = 0;
   int errors = 0;

   logic [15:0] prog [5] = '{16'h18A0, 16'h19C0, 16'h0204, 16'h2AE0, 16'hE001};

   always #5 clk = ~clk;

   risc_prog_loader #(.DEPTH(256), .RST_HOLD(9), .HLT_WORD(16'hE001)) dut (
      .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .ext_we(ext_we), .ext_data(ext_data), .ext_addr(ext_addr),
      .cpu_rst(cpu_rst), .cpu_done(cpu_done), .busy(busy), .err(err),
      .run_cycles(run_cycles)
   );

   risc_prog_loader #(.DEPTH(8), .RST_HOLD(9), .HLT_WORD(16'hE001)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready_8), .ext_we(ext_we_8), .ext_data(ext_data_8), .ext_addr(ext_addr_8),
      .cpu_rst(cpu_rst_8), .cpu_done(cpu_done), .busy(busy_8), .err(err_8),
      .run_cycles(run_cycles_8)
   );

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic expect_zero_outputs(input string tag);
      checks++;
      if ({cpu_rst, ext_we, in_ready, busy, err} !== 5'b0) begin
         errors++;
         $display("FAIL %s_flags got cpu_rst/we/ready/busy/err=%b expected 00000", tag,
                  {cpu_rst, ext_we, in_ready, busy, err});
      end
      checks++;
      if ({ext_data, ext_addr, run_cycles} !== 40'h0) begin
         errors++;
         $display("FAIL %s_regs got data=%h addr=%h run=%h expected all zero", tag,
                  ext_data, ext_addr, run_cycles);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      tick();
      expect_zero_outputs("reset_held");
      rst = 1'b1;
      tick();
      tick();
      expect_zero_outputs("reset_idle");
   endtask

   task automatic test_back_to_back;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({in_ready, busy} !== 2'b11) begin
         errors++;
         $display("FAIL b2b_enter_load got ready/busy=%b expected 11", {in_ready, busy});
      end
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = prog[i];
         tick();
         checks++;
         if ({ext_we, ext_data, ext_addr} !== {1'b1, prog[i], 8'(i)}) begin
            errors++;
            $display("FAIL b2b_write[%0d] got we=%b data=%h addr=%h expected we=1 data=%h addr=%h",
                     i, ext_we, ext_data, ext_addr, prog[i], 8'(i));
         end
      end
      in_valid = 1'b0;
      checks++;
      if ({in_ready, cpu_rst, busy} !== 3'b001) begin
         errors++;
         $display("FAIL b2b_after_hlt got ready/cpu_rst/busy=%b expected 001", {in_ready, cpu_rst, busy});
      end
      for (int j = 1; j <= 8; j++) begin
         tick();
         checks++;
         if (cpu_rst !== 1'b0 || (j == 1 && ext_we !== 1'b0)) begin
            errors++;
            $display("FAIL b2b_hold[%0d] got cpu_rst=%b we=%b expected cpu_rst=0 we=0", j, cpu_rst, ext_we);
         end
      end
      tick();
      checks++;
      if ({cpu_rst, busy, err} !== 3'b110) begin
         errors++;
         $display("FAIL b2b_release got cpu_rst/busy/err=%b expected 110", {cpu_rst, busy, err});
      end
   endtask

   task automatic test_run;
      repeat (40) tick();
      cpu_done = 1'b1;
      tick();
      checks++;
      if ({run_cycles, busy, cpu_rst} !== {16'd40, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL run_halt got run=%0d busy=%b cpu_rst=%b expected run=40 busy=0 cpu_rst=1",
                  run_cycles, busy, cpu_rst);
      end
      repeat (3) tick();
      cpu_done = 1'b0;
      checks++;
      if ({run_cycles, cpu_rst} !== {16'd40, 1'b1}) begin
         errors++;
         $display("FAIL run_frozen got run=%0d cpu_rst=%b expected run=40 cpu_rst=1", run_cycles, cpu_rst);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({cpu_rst, run_cycles, in_ready} !== {1'b0, 16'd0, 1'b1}) begin
         errors++;
         $display("FAIL run_restart got cpu_rst=%b run=%0d ready=%b expected cpu_rst=0 run=0 ready=1",
                  cpu_rst, run_cycles, in_ready);
      end
   endtask

   // Continues from the LOAD state entered at the end of test_run.
   task automatic test_gapped;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b0;
         tick();
         checks++;
         if (ext_we !== 1'b0) begin
            errors++;
            $display("FAIL gap_idle[%0d] got we=%b expected 0", i, ext_we);
         end
         in_valid = 1'b1;
         in_data  = prog[i];
         tick();
         checks++;
         if ({ext_we, ext_data, ext_addr} !== {1'b1, prog[i], 8'(i)}) begin
            errors++;
            $display("FAIL gap_write[%0d] got we=%b data=%h addr=%h expected we=1 data=%h addr=%h",
                     i, ext_we, ext_data, ext_addr, prog[i], 8'(i));
         end
      end
      in_valid = 1'b0;
      repeat (8) tick();
      checks++;
      if (cpu_rst !== 1'b0) begin
         errors++;
         $display("FAIL gap_hold got cpu_rst=%b expected 0", cpu_rst);
      end
      tick();
      checks++;
      if (cpu_rst !== 1'b1) begin
         errors++;
         $display("FAIL gap_release got cpu_rst=%b expected 1", cpu_rst);
      end
   endtask

   task automatic test_reset_midrun;
      repeat (3) tick();
      checks++;
      if ({run_cycles, busy} !== {16'd3, 1'b1}) begin
         errors++;
         $display("FAIL midrun_count got run=%0d busy=%b expected run=3 busy=1", run_cycles, busy);
      end
      #2 rst = 1'b0;
      #1 expect_zero_outputs("midrun_async");
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_reset_midload;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = prog[i];
         tick();
      end
      checks++;
      if (ext_addr !== 8'd2) begin
         errors++;
         $display("FAIL midload_progress got addr=%h expected 02", ext_addr);
      end
      in_data = prog[3];
      #2 rst = 1'b0;
      #1 expect_zero_outputs("midload_async");
      tick();
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      expect_zero_outputs("midload_idle");
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      in_data  = prog[0];
      tick();
      in_valid = 1'b0;
      checks++;
      if ({ext_we, ext_data, ext_addr} !== {1'b1, prog[0], 8'd0}) begin
         errors++;
         $display("FAIL reload_first got we=%b data=%h addr=%h expected we=1 data=%h addr=00",
                  ext_we, ext_data, ext_addr, prog[0]);
      end
   endtask

   // Continues from LOAD with word 0 already written by test_reset_midload.
   task automatic test_start_ignored;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({ext_we, in_ready, busy} !== 3'b011) begin
         errors++;
         $display("FAIL ign_load got we/ready/busy=%b expected 011", {ext_we, in_ready, busy});
      end
      for (int i = 1; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = prog[i];
         tick();
         checks++;
         if ({ext_data, ext_addr} !== {prog[i], 8'(i)}) begin
            errors++;
            $display("FAIL ign_write[%0d] got data=%h addr=%h expected data=%h addr=%h",
                     i, ext_data, ext_addr, prog[i], 8'(i));
         end
      end
      in_valid = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({cpu_rst, in_ready, busy} !== 3'b001) begin
         errors++;
         $display("FAIL ign_hold got cpu_rst/ready/busy=%b expected 001", {cpu_rst, in_ready, busy});
      end
      repeat (6) tick();
      checks++;
      if (cpu_rst !== 1'b0) begin
         errors++;
         $display("FAIL ign_hold_len got cpu_rst=%b expected 0", cpu_rst);
      end
      tick();
      checks++;
      if (cpu_rst !== 1'b1) begin
         errors++;
         $display("FAIL ign_release got cpu_rst=%b expected 1", cpu_rst);
      end
      cpu_done = 1'b1;
      tick();
      cpu_done = 1'b0;
      checks++;
      if ({run_cycles, busy, cpu_rst} !== {16'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL ign_quick_done got run=%0d busy=%b cpu_rst=%b expected run=0 busy=0 cpu_rst=1",
                  run_cycles, busy, cpu_rst);
      end
   endtask

   task automatic test_overflow;
      logic saw_rise;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = 16'h1000 + 16'(i);
         tick();
         checks++;
         if ({ext_we_8, ext_data_8, ext_addr_8} !== {1'b1, 16'h1000 + 16'(i), 3'(i)}) begin
            errors++;
            $display("FAIL ovf_write[%0d] got we=%b data=%h addr=%0d expected we=1 data=%h addr=%0d",
                     i, ext_we_8, ext_data_8, ext_addr_8, 16'h1000 + 16'(i), i);
         end
      end
      checks++;
      if ({err_8, in_ready_8, busy_8, cpu_rst_8} !== 4'b1000) begin
         errors++;
         $display("FAIL ovf_state got err/ready/busy/cpu_rst=%b expected 1000",
                  {err_8, in_ready_8, busy_8, cpu_rst_8});
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (ext_we_8 !== 1'b0) begin
         errors++;
         $display("FAIL ovf_no_write got we=%b expected 0", ext_we_8);
      end
      saw_rise = 1'b0;
      repeat (12) begin
         tick();
         if (cpu_rst_8 !== 1'b0) saw_rise = 1'b1;
      end
      checks++;
      if (saw_rise !== 1'b0 || err_8 !== 1'b1) begin
         errors++;
         $display("FAIL ovf_no_release got cpu_rst_seen=%b err=%b expected 0 and 1", saw_rise, err_8);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_run();
      test_gapped();
      test_reset_midrun();
      test_reset_midload();
      test_start_ignored();
      test_overflow();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
